// File: rtl/game_input_pkg.sv
// Shared types and constants for the game input conditioner (debouncer states, legal move range).
package game_input_pkg;

  typedef enum logic [1:0] {IDLE, PRESS_WT, HELD, REL_WT} btn_state_t;

  localparam logic [3:0] MOVE_MIN = 4'd1;
  localparam logic [3:0] MOVE_MAX = 4'd9;
  localparam int unsigned DEBOUNCE_DEFAULT = 500_000;

  function automatic logic move_legal(input logic [3:0] move);
    return (move >= MOVE_MIN) && (move <= MOVE_MAX);
  endfunction

endpackage

// File: rtl/button_debouncer.sv
// Synchronizes one active-low bouncy button and emits a single registered pulse per
// debounced press.
module button_debouncer
  import game_input_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
  input  logic clock,
  input  logic reset_L,
  input  logic btn_raw_L,
  output logic press_pulse
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);

  logic             sync_q1;
  logic             sync_q2;
  btn_state_t       state;
  btn_state_t       state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic [CNT_W-1:0] cnt_inc;
  logic             pulse_nxt;

  // Two-flop synchronizer; resets to the released level.
  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      sync_q1 <= 1'b1;
      sync_q2 <= 1'b1;
    end else begin
      sync_q1 <= btn_raw_L;
      sync_q2 <= sync_q1;
    end
  end

  // Saturating increment: the counter never wraps.
  assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + CNT_W'(1);

  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      state       <= IDLE;
      cnt         <= '0;
      press_pulse <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      press_pulse <= pulse_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    pulse_nxt = 1'b0;
    case (state)
      IDLE: begin
        if (!sync_q2) begin
          state_nxt = PRESS_WT;
          cnt_nxt   = CNT_W'(1);
        end
      end
      PRESS_WT: begin
        if (sync_q2) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else if (cnt == CNT_MAX) begin
          state_nxt = HELD;
          cnt_nxt   = '0;
          pulse_nxt = 1'b1;
        end else begin
          cnt_nxt = cnt_inc;
        end
      end
      HELD: begin
        if (sync_q2) begin
          state_nxt = REL_WT;
          cnt_nxt   = CNT_W'(1);
        end
      end
      REL_WT: begin
        if (!sync_q2) begin
          state_nxt = HELD;
          cnt_nxt   = '0;
        end else if (cnt == CNT_MAX) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt_inc;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

endmodule

// File: rtl/game_input_conditioner.sv
// Conditions DE2 enter/new-game buttons and move switches for the game FSM.
// Optional move range check enabled with `define MOVE_CHECK_EN.
module game_input_conditioner
  import game_input_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
  input  logic       clock,
  input  logic       reset_L,
  input  logic       enter_raw_L,
  input  logic       newgame_raw_L,
  input  logic [3:0] move_raw,
  output logic       enter,
  output logic       new_game,
  output logic [3:0] hMove,
  output logic       move_err
);

  logic       enter_press;
  logic       newgame_press;
  logic [3:0] move_q1;
  logic [3:0] move_q2;
  logic       move_ok;
  logic       enter_take;

  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_enter_db (
    .clock       (clock),
    .reset_L     (reset_L),
    .btn_raw_L   (enter_raw_L),
    .press_pulse (enter_press)
  );

  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_newgame_db (
    .clock       (clock),
    .reset_L     (reset_L),
    .btn_raw_L   (newgame_raw_L),
    .press_pulse (newgame_press)
  );

  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      move_q1 <= 4'h0;
      move_q2 <= 4'h0;
    end else begin
      move_q1 <= move_raw;
      move_q2 <= move_q1;
    end
  end

`ifdef MOVE_CHECK_EN
  assign move_ok = move_legal(move_q2);
`else
  assign move_ok = 1'b1;
`endif

  // New-game wins a same-cycle accept; the enter press is consumed without effect.
  assign enter_take = enter_press & ~newgame_press & move_ok;

  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      enter    <= 1'b0;
      new_game <= 1'b0;
      hMove    <= 4'h0;
    end else begin
      enter    <= enter_take;
      new_game <= newgame_press;
      if (enter_take) begin
        hMove <= move_q2;
      end
    end
  end

`ifdef MOVE_CHECK_EN
  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      move_err <= 1'b0;
    end else begin
      move_err <= enter_press & ~newgame_press & ~move_ok;
    end
  end
`else
  assign move_err = 1'b0;
`endif

endmodule

// File: tb/tb_game_input_conditioner.sv
// Randomized and directed bench for game_input_conditioner against a run-length
// reference model of the debounce rules.
module tb_game_input_conditioner;

  localparam int unsigned D = 4;

  logic       clock = 1'b0;
  logic       reset_L;
  logic       enter_raw_L;
  logic       newgame_raw_L;
  logic [3:0] move_raw;
  logic       enter;
  logic       new_game;
  logic [3:0] hMove;
  logic       move_err;

  game_input_conditioner #(.DEBOUNCE_CYCLES(D)) dut (
    .clock         (clock),
    .reset_L       (reset_L),
    .enter_raw_L   (enter_raw_L),
    .newgame_raw_L (newgame_raw_L),
    .move_raw      (move_raw),
    .enter         (enter),
    .new_game      (new_game),
    .hMove         (hMove),
    .move_err      (move_err)
  );

  always #5 clock = ~clock;

  int unsigned n_pass = 0;
  int unsigned n_total = 0;

  // Reference model: two-sample delay lines plus a debounced level per button.
  bit [1:0]    e_pipe, n_pipe;
  logic [3:0]  mv_pipe [2];
  bit          e_level, n_level;
  int unsigned e_run, n_run;
  bit          e_pend, n_pend;
  bit          x_enter, x_ng, x_err;
  logic [3:0]  x_hmove;

  // Per-test statistics gathered while stepping.
  int unsigned stepn, cyc_mis, mis_step;
  logic [6:0]  mis_obs, mis_exp;
  int unsigned cnt_e, cnt_ng, cnt_err, first_e, first_ng, exp_cnt_e, exp_cnt_ng;

  function automatic bit model_legal(input logic [3:0] m);
`ifdef MOVE_CHECK_EN
    return (m >= 4'd1) && (m <= 4'd9);
`else
    return 1'b1;
`endif
  endfunction

  // Level 0 = released. Because the button is active low, a sample equal to the
  // level is the "opposite" state; D+1 such samples in a row flip the level.
  function automatic void btn_adv(input bit smp, inout bit level, inout int unsigned run,
                                  output bit pulse);
    pulse = 1'b0;
    if (smp == level) begin
      run++;
      if (run == D + 1) begin
        level = ~level;
        run   = 0;
        pulse = level;
      end
    end else begin
      run = 0;
    end
  endfunction

  function automatic void model_reset();
    e_pipe = 2'b11; n_pipe = 2'b11;
    mv_pipe[0] = 4'h0; mv_pipe[1] = 4'h0;
    e_level = 1'b0; n_level = 1'b0; e_run = 0; n_run = 0;
    e_pend = 1'b0; n_pend = 1'b0;
    x_enter = 1'b0; x_ng = 1'b0; x_err = 1'b0; x_hmove = 4'h0;
  endfunction

  function automatic void model_step(input bit e, input bit n, input logic [3:0] m);
    bit legal;
    legal   = model_legal(mv_pipe[1]);
    x_enter = e_pend && !n_pend && legal;
    x_ng    = n_pend;
    x_err   = e_pend && !n_pend && !legal;
    if (x_enter) x_hmove = mv_pipe[1];
    btn_adv(e_pipe[1], e_level, e_run, e_pend);
    btn_adv(n_pipe[1], n_level, n_run, n_pend);
    e_pipe = {e_pipe[0], e};
    n_pipe = {n_pipe[0], n};
    mv_pipe[1] = mv_pipe[0];
    mv_pipe[0] = m;
  endfunction

  task automatic clear_stats();
    stepn = 0; cyc_mis = 0; mis_step = 0; mis_obs = '0; mis_exp = '0;
    cnt_e = 0; cnt_ng = 0; cnt_err = 0; first_e = 0; first_ng = 0;
    exp_cnt_e = 0; exp_cnt_ng = 0;
  endtask

  // Drive one cycle of inputs at a negedge, sample outputs at the next negedge.
  task automatic step(input bit e, input bit n, input logic [3:0] m);
    enter_raw_L = e; newgame_raw_L = n; move_raw = m;
    model_step(e, n, m);
    @(negedge clock);
    stepn++;
    if ({enter, new_game, hMove, move_err} !== {x_enter, x_ng, x_hmove, x_err}) begin
      if (cyc_mis == 0) begin
        mis_step = stepn;
        mis_obs  = {enter, new_game, hMove, move_err};
        mis_exp  = {x_enter, x_ng, x_hmove, x_err};
      end
      cyc_mis++;
    end
    if (x_enter) exp_cnt_e++;
    if (x_ng) exp_cnt_ng++;
    if (enter === 1'b1) begin cnt_e++; if (first_e == 0) first_e = stepn; end
    if (new_game === 1'b1) begin cnt_ng++; if (first_ng == 0) first_ng = stepn; end
    if (move_err === 1'b1) cnt_err++;
  endtask

  task automatic seg(input bit e, input bit n, input logic [3:0] m, input int len);
    for (int i = 0; i < len; i++) step(e, n, m);
  endtask

  task automatic test_reset();
    reset_L = 1'b0; enter_raw_L = 1'b1; newgame_raw_L = 1'b1; move_raw = 4'h0;
    model_reset();
    clear_stats();
    #1;
    n_total++;
    if ({enter, new_game, hMove, move_err} !== 7'd0)
      $display("FAIL reset_outputs: got %b want 0000000", {enter, new_game, hMove, move_err});
    else n_pass++;
    repeat (3) @(negedge clock);
    reset_L = 1'b1;
    seg(1, 1, 4'h0, 5);
    n_total++;
    if ({enter, new_game, hMove, move_err} !== 7'd0 || cyc_mis != 0)
      $display("FAIL reset_idle: got %b want 0000000", {enter, new_game, hMove, move_err});
    else n_pass++;
  endtask

  task automatic test_clean_press();
    clear_stats();
    seg(0, 1, 4'd3, 20);
    seg(1, 1, 4'd3, 15);
    n_total++;
    if (cyc_mis !== 0)
      $display("FAIL clean_model: step %0d got %b want %b", mis_step, mis_obs, mis_exp);
    else n_pass++;
    n_total++;
    if (cnt_e !== 1) $display("FAIL clean_count: got %0d want 1", cnt_e); else n_pass++;
    n_total++;
    if (first_e !== D + 4) $display("FAIL clean_latency: got %0d want %0d", first_e, D + 4);
    else n_pass++;
    n_total++;
    if (hMove !== 4'd3) $display("FAIL clean_hmove: got %0d want 3", hMove); else n_pass++;
  endtask

  task automatic test_bounce();
    clear_stats();
    for (int k = 0; k < 12; k++) step(bit'((k / 2) % 2), 1, 4'd3);
    seg(0, 1, 4'd3, 15);
    seg(1, 1, 4'd3, 15);
    n_total++;
    if (cyc_mis !== 0)
      $display("FAIL bounce_model: step %0d got %b want %b", mis_step, mis_obs, mis_exp);
    else n_pass++;
    n_total++;
    if (cnt_e !== 1) $display("FAIL bounce_count: got %0d want 1", cnt_e); else n_pass++;
    n_total++;
    if (first_e !== 12 + D + 4) $display("FAIL bounce_latency: got %0d want %0d", first_e, 12 + D + 4);
    else n_pass++;
  endtask

  task automatic test_hold_repress();
    clear_stats();
    seg(0, 1, 4'd3, 50);
    seg(1, 1, 4'd3, 2);
    seg(0, 1, 4'd3, 50);
    seg(1, 1, 4'd3, 15);
    seg(0, 1, 4'd3, 20);
    seg(1, 1, 4'd3, 15);
    n_total++;
    if (cyc_mis !== 0)
      $display("FAIL hold_model: step %0d got %b want %b", mis_step, mis_obs, mis_exp);
    else n_pass++;
    n_total++;
    if (cnt_e !== 2) $display("FAIL hold_count: got %0d want 2", cnt_e); else n_pass++;
  endtask

  task automatic test_simultaneous();
    clear_stats();
    seg(0, 0, 4'd5, 20);
    seg(1, 1, 4'd5, 15);
    n_total++;
    if (cyc_mis !== 0)
      $display("FAIL simul_model: step %0d got %b want %b", mis_step, mis_obs, mis_exp);
    else n_pass++;
    n_total++;
    if (cnt_ng !== 1 || first_ng !== D + 4)
      $display("FAIL simul_newgame: got count %0d at %0d want 1 at %0d", cnt_ng, first_ng, D + 4);
    else n_pass++;
    n_total++;
    if (cnt_e !== 0) $display("FAIL simul_enter: got %0d want 0", cnt_e); else n_pass++;
    n_total++;
    if (hMove !== 4'd3) $display("FAIL simul_hmove: got %0d want 3", hMove); else n_pass++;
  endtask

  task automatic test_reset_mid_press();
    clear_stats();
    seg(0, 1, 4'd6, 5);
    reset_L = 1'b0;
    #1;
    n_total++;
    if ({enter, new_game, hMove, move_err} !== 7'd0)
      $display("FAIL midrst_async: got %b want 0000000", {enter, new_game, hMove, move_err});
    else n_pass++;
    repeat (2) @(negedge clock);
    reset_L = 1'b1;
    model_reset();
    clear_stats();
    seg(0, 1, 4'd6, 15);
    seg(1, 1, 4'd6, 15);
    n_total++;
    if (cyc_mis !== 0)
      $display("FAIL midrst_model: step %0d got %b want %b", mis_step, mis_obs, mis_exp);
    else n_pass++;
    n_total++;
    if (cnt_e !== 1 || first_e !== D + 4)
      $display("FAIL midrst_pulse: got count %0d at %0d want 1 at %0d", cnt_e, first_e, D + 4);
    else n_pass++;
    n_total++;
    if (hMove !== 4'd6) $display("FAIL midrst_hmove: got %0d want 6", hMove); else n_pass++;
  endtask

  task automatic test_move_check();
    clear_stats();
    seg(0, 1, 4'd0, 15);
    seg(1, 1, 4'd0, 15);
    seg(0, 1, 4'd12, 15);
    seg(1, 1, 4'd12, 15);
`ifdef MOVE_CHECK_EN
    n_total++;
    if (cnt_err !== 2 || cnt_e !== 0)
      $display("FAIL move_illegal: got err %0d enter %0d want err 2 enter 0", cnt_err, cnt_e);
    else n_pass++;
    n_total++;
    if (hMove !== 4'd6) $display("FAIL move_illegal_hold: got %0d want 6", hMove); else n_pass++;
`else
    n_total++;
    if (cnt_err !== 0 || cnt_e !== 2)
      $display("FAIL move_any: got err %0d enter %0d want err 0 enter 2", cnt_err, cnt_e);
    else n_pass++;
    n_total++;
    if (hMove !== 4'd12) $display("FAIL move_any_hmove: got %0d want 12", hMove); else n_pass++;
`endif
    seg(0, 1, 4'd9, 15);
    seg(1, 1, 4'd9, 15);
    n_total++;
    if (hMove !== 4'd9) $display("FAIL move_nine: got %0d want 9", hMove); else n_pass++;
    n_total++;
    if (cyc_mis !== 0)
      $display("FAIL move_model: step %0d got %b want %b", mis_step, mis_obs, mis_exp);
    else n_pass++;
  endtask

  task automatic test_random();
    clear_stats();
    for (int s = 0; s < 200; s++)
      seg(bit'($urandom_range(0, 1)), bit'($urandom_range(0, 3) != 0),
          4'($urandom_range(0, 15)), int'($urandom_range(1, 12)));
    seg(1, 1, 4'd0, 15);
    n_total++;
    if (cyc_mis !== 0)
      $display("FAIL random_model: %0d bad cycles, first step %0d got %b want %b",
               cyc_mis, mis_step, mis_obs, mis_exp);
    else n_pass++;
    n_total++;
    if (cnt_e !== exp_cnt_e || cnt_ng !== exp_cnt_ng)
      $display("FAIL random_counts: got enter %0d ng %0d want enter %0d ng %0d",
               cnt_e, cnt_ng, exp_cnt_e, exp_cnt_ng);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_hold_repress();
    test_simultaneous();
    test_reset_mid_press();
    test_move_check();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
